// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and the writeback record used by the register-file write path.
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: pipeline and late-return writeback requests plus register-file write port.
interface regfile_write_arbiter_if;
    import mips_pkg::*;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0]     alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [REG_ADDR_W-1:0] ld_reg;
    logic [DATA_W-1:0]     ld_data;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;
    logic [31:0]           busy_mask;
    modport slave (
        input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        output alu_ready, ld_ready, regWrite, write_reg, write_data, busy_mask
    );
    modport master (
        output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
        input  alu_ready, ld_ready, regWrite, write_reg, write_data, busy_mask
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: ordered buffer of late-return writebacks; exposes occupancy and a destination scoreboard.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  wb_entry_t                din_i,
    input  logic                     pop_i,
    output wb_entry_t                dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              busy_mask_o
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t        mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
            valid_q <= (valid_q & ~(DEPTH'(pop_i) << rd_q)) | (DEPTH'(push_i) << wr_q);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    assign dout_o  = mem_q[rd_q];
    assign count_o = count_q;
    // Register 0 is never a real destination, so it never blocks the hazard unit.
    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i]) busy_mask_o[mem_q[i].reg_addr] = 1'b1;
        busy_mask_o[0] = 1'b0;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges pipeline and late-return writebacks into one register-file write port,
// buffering losing loads in order and force-granting them after a bounded number of pipeline wins.
module regfile_write_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0]         starve_q, starve_d;
    logic                  regwrite_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     write_data_q;
    logic [AW:0]           count;
    logic                  empty, force_buf, bypass, deq, enq, grant;
    wb_entry_t             head, alu_e, ld_e, grant_e;
    assign alu_e = {bus.alu_reg, bus.alu_data};
    assign ld_e  = {bus.ld_reg, bus.ld_data};
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (enq),
        .din_i      (ld_e),
        .pop_i      (deq),
        .dout_o     (head),
        .count_o    (count),
        .busy_mask_o(bus.busy_mask)
    );
    assign bus.alu_ready = !force_buf;
    assign bus.ld_ready  = count < (AW+1)'(DEPTH);
    // The starvation counter is cleared whenever the buffer is empty, so a force implies a valid head.
    always_comb begin
        empty     = count == '0;
        force_buf = starve_q == CW'(STARVE_LIMIT);
        deq       = force_buf || (!bus.alu_valid && !empty);
        bypass    = !force_buf && !bus.alu_valid && empty && bus.ld_valid;
        enq       = bus.ld_valid && bus.ld_ready && !bypass;
        grant     = deq || bus.alu_valid || bypass;
        grant_e   = deq ? head : bus.alu_valid ? alu_e : ld_e;
        starve_d  = (deq || empty) ? '0 :
                    (bus.alu_valid && !force_buf) ? starve_q + 1'b1 : starve_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q     <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            starve_q   <= starve_d;
            regwrite_q <= grant && grant_e.reg_addr != '0;
            if (grant) begin
                write_reg_q  <= grant_e.reg_addr;
                write_data_q <= grant_e.data;
            end
        end
    end
    assign bus.regWrite   = regwrite_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_regfile_write_arbiter;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    regfile_write_arbiter_if bus();
    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        cwd;
        logic [31:0] busy;
    } vec_t;
    vec_t v[12];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic set_idle();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
    endtask
    task automatic reset_dut();
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.ld_valid = 1'b0;  bus.ld_reg = '0;  bus.ld_data = '0;
        v[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        v[1]  = '{1, 5, 32'h12345678, 0, 0, 0, 1, 5, 32'h12345678, 1, 0};
        v[2]  = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0};
        v[3]  = '{1, 9, 32'h99, 0, 0, 0, 1, 9, 32'h99, 1, 0};
        v[4]  = '{0, 0, 0, 0, 0, 0, 0, 9, 32'h99, 1, 0};
        v[5]  = '{1, 3, 32'hA, 1, 7, 32'hB, 1, 3, 32'hA, 1, 32'h80};
        v[6]  = '{0, 0, 0, 0, 0, 0, 1, 7, 32'hB, 1, 0};
        v[7]  = '{0, 0, 0, 1, 12, 32'hC, 1, 12, 32'hC, 1, 0};
        v[8]  = '{0, 0, 0, 0, 0, 0, 0, 12, 32'hC, 1, 0};
        v[9]  = '{0, 0, 0, 1, 0, 32'hD, 0, 0, 0, 0, 0};
        v[10] = '{1, 4, 32'hE, 1, 0, 32'hF, 1, 4, 32'hE, 1, 0};
        v[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        reset_dut();
        chk("reset_out", {bus.regWrite, bus.write_reg, bus.write_data}, '0);
        chk("reset_ready", {bus.alu_ready, bus.ld_ready}, 2'b11);
        chk("reset_busy", bus.busy_mask, 0);
        for (int i = 0; i < 12; i++) begin
            bus.alu_valid = v[i].av; bus.alu_reg = v[i].ar; bus.alu_data = v[i].ad;
            bus.ld_valid = v[i].lv;  bus.ld_reg = v[i].lr;  bus.ld_data = v[i].ld;
            step();
            chk($sformatf("vec%0d_we", i), bus.regWrite, v[i].we);
            if (v[i].cwd) chk($sformatf("vec%0d_wdata", i), {bus.write_reg, bus.write_data}, {v[i].wr, v[i].wd});
            chk($sformatf("vec%0d_busy", i), bus.busy_mask, v[i].busy);
            chk($sformatf("vec%0d_ready", i), {bus.alu_ready, bus.ld_ready}, 2'b11);
        end
        set_idle();
        begin : fill
            int k = 1, acc = 0, first_drop = -1, alu_acc = 0, alu_w = 0;
            logic [4:0] seen[$];
            logic la, aa;
            reset_dut();
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd16; bus.alu_data = 32'h5000;
            for (int c = 0; c < 80 && seen.size() < 5; c++) begin
                bus.ld_valid = k <= 5;
                bus.ld_reg = 5'(k);
                bus.ld_data = 32'(100 + k);
                if (k <= 5 && !bus.ld_ready && first_drop < 0) first_drop = acc;
                la = bus.ld_valid && bus.ld_ready;
                aa = bus.alu_valid && bus.alu_ready;
                step();
                if (la) begin k++; acc++; end
                if (aa) begin
                    alu_acc++;
                    bus.alu_reg = 5'(16 + alu_acc % 16);
                    bus.alu_data = 32'h5000 + 32'(alu_acc);
                end
                bus.alu_valid = k <= 5;
                if (bus.regWrite) begin
                    if (bus.write_reg < 5'd16) begin
                        seen.push_back(bus.write_reg);
                        chk("fill_ld_data", bus.write_data, 32'(100 + int'(bus.write_reg)));
                    end else alu_w++;
                end
            end
            set_idle();
            chk("fill_drop_after", first_drop, 4);
            chk("fill_drained", seen.size(), 5);
            for (int i = 0; i < seen.size(); i++) chk($sformatf("fill_order%0d", i), seen[i], 5'(i + 1));
            chk("fill_alu_writes", alu_w, alu_acc);
            step();
            chk("fill_empty", {bus.ld_ready, bus.busy_mask}, {1'b1, 32'h0});
        end
        begin : starve
            reset_dut();
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd10; bus.alu_data = 32'h55;
            bus.ld_valid = 1'b1;  bus.ld_reg = 5'd2;   bus.ld_data = 32'h77;
            step();
            bus.ld_valid = 1'b0;
            chk("starve_busy", bus.busy_mask, 32'h4);
            for (int i = 1; i <= 9; i++) begin
                chk($sformatf("starve_ready%0d", i), bus.alu_ready, i == 9 ? 1'b0 : 1'b1);
                step();
            end
            chk("starve_ld_write", {bus.regWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd2, 32'h77});
            chk("starve_ready_back", bus.alu_ready, 1'b1);
            chk("starve_busy_clr", bus.busy_mask, 0);
            step();
            chk("starve_alu_resume", {bus.regWrite, bus.write_reg, bus.write_data}, {1'b1, 5'd10, 32'h55});
            set_idle();
        end
        begin : mid_reset
            int stale = 0;
            reset_dut();
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd20; bus.alu_data = 32'h1;
            for (int i = 1; i <= 3; i++) begin
                bus.ld_valid = 1'b1; bus.ld_reg = 5'(i); bus.ld_data = 32'(i);
                step();
            end
            bus.ld_valid = 1'b0;
            chk("mid_busy_before", bus.busy_mask, 32'hE);
            #2 rst = 1'b1;
            #1;
            chk("mid_busy_async", bus.busy_mask, 0);
            chk("mid_out_async", {bus.regWrite, bus.write_reg, bus.write_data}, '0);
            chk("mid_ready_async", {bus.alu_ready, bus.ld_ready}, 2'b11);
            set_idle();
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (bus.regWrite || bus.busy_mask != 0) stale++;
            end
            chk("mid_no_stale", stale, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
